logic32_resp: RTL

//  Sequential responder for 32-bit bitwise primitive requests (AND/OR/NOT).

---
 rtl/primitives32_pkg.sv | 37 +++
 rtl/logic32_fifo.sv | 74 +++++++
 rtl/logic32_resp.sv | 88 ++++++++
 3 files changed

// File: rtl/primitives32_pkg.sv
// Shared types and the combinational operation model for the 32-bit
// bitwise primitive responder (AND / OR / NOT, plus an illegal code).
package primitives32_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_NOT = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  // One buffered response: result word plus illegal-op flag.
  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             err;
  } resp_t;

  // Pure decode of one request. NOT ignores y; the illegal code
  // yields a zero result with err set so the initiator can tell it apart.
  function automatic resp_t eval_op(input op_e              op,
                                    input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y);
    resp_t r;
    r = '0;
    case (op)
      OP_AND:  r.z   = x & y;
      OP_OR:   r.z   = x | y;
      OP_NOT:  r.z   = ~x;
      OP_ILL:  r.err = 1'b1;
      default: r     = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic32_fifo.sv
// Small synchronous FIFO for responses. Head is read directly from
// storage at the read pointer, so it stays stable until a pop.
// Push is refused when full, pop is ignored when empty.
module logic32_fifo
  import primitives32_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = resp_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  T              mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; DEPTH is a power of two so
  // the pointers wrap naturally at their width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/logic32_resp.sv
// Sequential responder for 32-bit bitwise requests. Each accepted request
// is evaluated combinationally, registered into a response FIFO and
// returned in order on the response channel.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready depends only on registered FIFO occupancy (no path from
// resp_ready), and the response head holds stable while resp_valid is high
// and resp_ready is low. Inputs of a channel are ignored while its
// ready/valid qualifier is low.
module logic32_resp
  import primitives32_pkg::*;
#(
  parameter int WIDTH = 32,   // must match the packaged resp_t word width
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_z,
  output logic             resp_err,
  output logic [CNT_W-1:0] req_count,
  output logic             err_seen
);

  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  resp_t      new_resp;
  resp_t      head;
  logic [CNT_W-1:0] req_count_q, req_count_d;
  logic             err_seen_q,  err_seen_d;

  assign req_ready  = ~fifo_full;
  assign resp_valid = ~fifo_empty;
  assign push       = req_valid & req_ready;
  assign pop        = resp_valid & resp_ready;

  assign new_resp   = eval_op(op_e'(req_op), req_x, req_y);

  assign resp_z     = head.z;
  assign resp_err   = head.err;
  assign req_count  = req_count_q;
  assign err_seen   = err_seen_q;

  logic32_fifo #(
    .DEPTH (DEPTH),
    .T     (resp_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (new_resp),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accepted-request counter (wraps) and sticky illegal-op flag.
  always_comb begin
    req_count_d = req_count_q;
    err_seen_d  = err_seen_q;
    if (push) begin
      req_count_d = req_count_q + 1'b1;
      if (op_e'(req_op) == OP_ILL) err_seen_d = 1'b1;
    end
  end

  // Status registers; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_count_q <= '0;
      err_seen_q  <= 1'b0;
    end else begin
      req_count_q <= req_count_d;
      err_seen_q  <= err_seen_d;
    end
  end

endmodule
